// File: rtl/cla_slice_scheduler_pkg.sv
// Shared types and constants for the CLA slice scheduler.
// The state enum, the default slice width, and the beat-count and index-width
// helpers live here so that the top and the arbiter size themselves consistently.
package cla_sched_pkg;

    localparam int unsigned DEF_SLICE = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of slice beats needed for one full-width addition.
    function automatic int unsigned nbeats(input int unsigned width, input int unsigned slice);
        return width / slice;
    endfunction

    // Width of an index over n items, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cla_slice_scheduler_arb.sv
// Round-robin arbiter for the CLA slice scheduler.
// Grants the lowest requester index at or above rr_ptr that has req_valid set,
// wrapping around to index 0. Outputs a one-hot grant, its index, and whether
// any requester was granted.
module cla_rr_arbiter
    import cla_sched_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]               req_valid,
    input  logic [id_width(NREQ)-1:0]     rr_ptr,
    output logic [NREQ-1:0]               grant,
    output logic [id_width(NREQ)-1:0]     grant_idx,
    output logic                          grant_any
);

    localparam int unsigned IDW = id_width(NREQ);

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned idx;
            idx = 32'(rr_ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_any && req_valid[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/cla_slice_scheduler.sv
// CLA slice scheduler: shares one external SLICE-bit combinational carry-lookahead
// adder slice between NREQ requesters. Each WIDTH-bit addition is sequenced over
// WIDTH/SLICE beats, least significant slice first, with the carry registered
// between beats. The accepted operation's result is held until rsp_ready.
// Optional build macro: CLA_SCHED_OVF_EN adds the rsp_ovf two's-complement
// overflow output, registered alongside rsp_sum.
module cla_slice_scheduler
    import cla_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned SLICE = DEF_SLICE,
    parameter int unsigned NREQ  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*WIDTH-1:0]         req_a,
    input  logic [NREQ*WIDTH-1:0]         req_b,
    input  logic [NREQ-1:0]               req_cin,
    output logic [SLICE-1:0]              sl_a,
    output logic [SLICE-1:0]              sl_b,
    output logic                          sl_cin,
    input  logic [SLICE-1:0]              sl_s,
    input  logic                          sl_cout,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [id_width(NREQ)-1:0]     rsp_id,
    output logic [WIDTH-1:0]              rsp_sum,
    output logic                          rsp_cout
`ifdef CLA_SCHED_OVF_EN
    ,
    output logic                          rsp_ovf
`endif
);

    localparam int unsigned NBEATS = nbeats(WIDTH, SLICE);
    localparam int unsigned IDW    = id_width(NREQ);
    localparam int unsigned BW     = id_width(NBEATS);

    localparam logic [BW-1:0]  LAST_BEAT = BW'(NBEATS - 1);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);

    if (((WIDTH % SLICE) != 0) || (NREQ < 2)) begin : g_cfg_check
        $error("cla_slice_scheduler: WIDTH must be a multiple of SLICE and NREQ must be >= 2");
    end

    state_t           state;
    state_t           state_nx;
    logic [IDW-1:0]   rr_ptr;
    logic [BW-1:0]    beat;
    logic             carry_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             cin_reg;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic             last_beat;

    cla_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign last_beat = (beat == LAST_BEAT);
    assign rsp_valid = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, request accept and slice operand drive.
    always_comb begin
        state_nx  = state;
        req_ready = '0;
        sl_a      = '0;
        sl_b      = '0;
        sl_cin    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    req_ready = grant;
                    state_nx  = RUN;
                end
            end
            RUN: begin
                sl_a   = a_reg[beat*SLICE +: SLICE];
                sl_b   = b_reg[beat*SLICE +: SLICE];
                sl_cin = (beat == '0) ? cin_reg : carry_reg;
                if (last_beat) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand capture on accept, per-beat sum/carry accumulation, and the
    // result registers that stay stable while the response waits in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            beat      <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            cin_reg   <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        a_reg   <= req_a[grant_idx*WIDTH +: WIDTH];
                        b_reg   <= req_b[grant_idx*WIDTH +: WIDTH];
                        cin_reg <= req_cin[grant_idx];
                        rsp_id  <= grant_idx;
                        beat    <= '0;
                        rr_ptr  <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
                    end
                end
                RUN: begin
                    rsp_sum[beat*SLICE +: SLICE] <= sl_s;
                    carry_reg <= sl_cout;
                    if (last_beat) begin
                        // Parked at 0 rather than k+1 so it never indexes past the top slice.
                        beat     <= '0;
                        rsp_cout <= sl_cout;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CLA_SCHED_OVF_EN
    // Signed overflow, captured on the final beat together with the top sum slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_ovf <= 1'b0;
        end else if ((state == RUN) && last_beat) begin
            rsp_ovf <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sl_s[SLICE-1] != a_reg[WIDTH-1]);
        end
    end
`endif

endmodule
